// File: rtl/rpn_stack_ctrl.sv
// Operand-stack sequencer for the RPN calculator: pushes numbers, issues two-operand
// ALU operations from the top of the stack and writes the result back in one EXEC cycle.
module rpn_stack_ctrl #(
  parameter  int N     = 16,
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          EnterPulse,
  input  logic          IsOp,
  input  logic          Clear,
  input  logic [N-1:0]  DataIn,
  output logic [N-1:0]  AluA,
  output logic [N-1:0]  AluB,
  output logic [1:0]    AluOpCode,
  input  logic [N-1:0]  AluResult,
  input  logic [4:0]    AluFlags,
  output logic [N-1:0]  Top,
  output logic [4:0]    Flags,
  output logic [DW-1:0] Depth,
  output logic          Busy,
  output logic          Error,
  output logic [2:0]    Status
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_OVF  = 3'd4,
    S_UNF  = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   stack_q [DEPTH];
  logic [N-1:0]   stack_d [DEPTH];
  logic [DW-1:0]  d_q, d_d;
  logic [1:0]     op_q, op_d;
  logic [4:0]     flags_q, flags_d;

  // Next-state logic: Clear overrides any EnterPulse; EXEC ignores the pulse entirely.
  always_comb begin
    state_d = state_q;
    stack_d = stack_q;
    d_d     = d_q;
    op_d    = op_q;
    flags_d = flags_q;
    if (Clear) begin
      d_d     = {DW{1'b0}};
      flags_d = 5'd0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (EnterPulse && !IsOp) begin
            if (d_q < DW'(DEPTH)) begin
              for (int i = 0; i < DEPTH; i++) begin
                stack_d[i] = (d_q == DW'(i)) ? DataIn : stack_q[i];
              end
              d_d = d_q + DW'(1);
            end else begin
              state_d = S_OVF;
            end
          end else if (EnterPulse && IsOp) begin
            if (d_q >= DW'(2)) begin
              op_d    = DataIn[1:0];
              state_d = S_EXEC;
            end else begin
              state_d = S_UNF;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_EXEC: begin
          // Result replaces operand A; operand B's slot is popped by the decrement.
          for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = (d_q == DW'(i + 2)) ? AluResult : stack_q[i];
          end
          d_d     = d_q - DW'(1);
          flags_d = AluFlags;
          state_d = S_IDLE;
        end
        S_OVF:   state_d = S_OVF;
        S_UNF:   state_d = S_UNF;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, stack and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      d_q     <= {DW{1'b0}};
      op_q    <= 2'd0;
      flags_q <= 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= {N{1'b0}};
      end
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      op_q    <= op_d;
      flags_q <= flags_d;
      stack_q <= stack_d;
    end
  end

  // Depth-qualified views of the stack; empty slots read as zero.
  always_comb begin
    Top  = {N{1'b0}};
    AluA = {N{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      Top = (d_q == DW'(i + 1)) ? stack_q[i] : Top;
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      AluA = (d_q == DW'(i + 2)) ? stack_q[i] : AluA;
    end
  end

  assign AluB      = Top;
  assign AluOpCode = op_q;
  assign Flags     = flags_q;
  assign Depth     = d_q;
  assign Status    = state_q;
  assign Busy      = (state_q == S_EXEC);
  assign Error     = (state_q == S_OVF) || (state_q == S_UNF);

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Self-checking bench for rpn_stack_ctrl: a queue-based stack model drives the expected
// values, with a directed vector table, hand-written corner sequences and random traffic.
module tb_rpn_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        EnterPulse, IsOp, Clear;
  logic [15:0] DataIn;
  logic [15:0] AluA, AluB, AluResult, Top;
  logic [1:0]  AluOpCode;
  logic [4:0]  AluFlags, Flags;
  logic [2:0]  Depth, Status;
  logic        Busy, Error;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of values plus a mode number (0 idle, 1 exec, 4 ovf, 5 unf).
  logic [15:0] mq[$];
  logic [1:0]  m_op;
  logic [4:0]  m_flags;
  int          m_mode;

  logic        r_ep, r_isop, r_clr;
  logic [15:0] r_din;

  typedef struct {
    logic        ep;
    logic        isop;
    logic        clr;
    logic [15:0] din;
    logic [15:0] top;
    logic [2:0]  depth;
    logic [2:0]  status;
    logic        busy;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  // Bench ALU: 00 add, 01 sub, 10 or, 11 and. Flags = {parity, overflow, negative, carry, zero}.
  function automatic logic [20:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, v;
    s = 17'd0; c = 1'b0; v = 1'b0; r = 16'd0;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
      2'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16]; v = (a[15] != b[15]) && (r[15] != a[15]); end
      2'd2: r = a | b;
      default: r = a & b;
    endcase
    return {^r, v, r[15], c, (r == 16'd0), r};
  endfunction

  assign {AluFlags, AluResult} = alu_f(AluA, AluB, AluOpCode);

  rpn_stack_ctrl #(.N(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .EnterPulse(EnterPulse), .IsOp(IsOp), .Clear(Clear),
    .DataIn(DataIn), .AluA(AluA), .AluB(AluB), .AluOpCode(AluOpCode),
    .AluResult(AluResult), .AluFlags(AluFlags), .Top(Top), .Flags(Flags),
    .Depth(Depth), .Busy(Busy), .Error(Error), .Status(Status)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_op    = 2'd0;
    m_flags = 5'd0;
    m_mode  = 0;
  endtask

  task automatic model_edge(input logic ep, input logic isop, input logic clr, input logic [15:0] din);
    logic [20:0] rr;
    logic [15:0] a, b;
    if (clr) begin
      mq.delete();
      m_flags = 5'd0;
      m_mode  = 0;
    end else if (m_mode == 1) begin
      b  = mq.pop_back();
      a  = mq.pop_back();
      rr = alu_f(a, b, m_op);
      mq.push_back(rr[15:0]);
      m_flags = rr[20:16];
      m_mode  = 0;
    end else if (m_mode == 0 && ep) begin
      if (!isop) begin
        if (mq.size() < 4) mq.push_back(din);
        else m_mode = 4;
      end else begin
        if (mq.size() >= 2) begin
          m_op   = din[1:0];
          m_mode = 1;
        end else begin
          m_mode = 5;
        end
      end
    end
  endtask

  task automatic check_all();
    int n;
    logic [15:0] e_top, e_a;
    n = mq.size();
    e_top = 16'd0;
    e_a   = 16'd0;
    if (n >= 1) e_top = mq[n-1];
    if (n >= 2) e_a = mq[n-2];
    chk("top", Top, e_top);
    chk("alu_b", AluB, e_top);
    chk("alu_a", AluA, e_a);
    chk("depth", 16'(Depth), 16'(n));
    chk("status", 16'(Status), 16'(m_mode));
    chk("busy", 16'(Busy), 16'(m_mode == 1));
    chk("error", 16'(Error), 16'(m_mode >= 4));
    chk("flags", 16'(Flags), 16'(m_flags));
    chk("opcode", 16'(AluOpCode), 16'(m_op));
  endtask

  task automatic tick(input logic ep, input logic isop, input logic clr, input logic [15:0] din);
    EnterPulse = ep;
    IsOp       = isop;
    Clear      = clr;
    DataIn     = din;
    @(posedge clk);
    model_edge(ep, isop, clr, din);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    EnterPulse = 1'b0; IsOp = 1'b0; Clear = 1'b0; DataIn = 16'd0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'd3, 16'd3, 3'd1, 3'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 16'd4, 16'd4, 3'd2, 3'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 16'd0, 16'd4, 3'd2, 3'd1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd7, 3'd1, 3'd0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 16'd5, 16'd5, 3'd2, 3'd0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 16'd1, 16'd5, 3'd2, 3'd1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd2, 3'd1, 3'd0, 1'b0};

    reset = 1'b1;
    do_reset();
    chk("rst_top", Top, 16'd0);
    chk("rst_status", 16'(Status), 16'd0);

    // Chained operations from the vector table.
    for (int i = 0; i < 7; i++) begin
      tick(tbl[i].ep, tbl[i].isop, tbl[i].clr, tbl[i].din);
      chk("tbl_top", Top, tbl[i].top);
      chk("tbl_depth", 16'(Depth), 16'(tbl[i].depth));
      chk("tbl_status", 16'(Status), 16'(tbl[i].status));
      chk("tbl_busy", 16'(Busy), 16'(tbl[i].busy));
    end

    // Overflow, ignored op while sticky, then Clear.
    tick(1'b0, 1'b0, 1'b1, 16'd0);
    for (int i = 1; i <= 4; i++) tick(1'b1, 1'b0, 1'b0, 16'(i));
    tick(1'b1, 1'b0, 1'b0, 16'd9);
    chk("ovf_status", 16'(Status), 16'd4);
    chk("ovf_error", 16'(Error), 16'd1);
    chk("ovf_top", Top, 16'd4);
    chk("ovf_depth", 16'(Depth), 16'd4);
    tick(1'b1, 1'b1, 1'b0, 16'd0);
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    chk("ovf_hold_status", 16'(Status), 16'd4);
    chk("ovf_hold_top", Top, 16'd4);
    tick(1'b0, 1'b0, 1'b1, 16'd0);
    chk("clr_status", 16'(Status), 16'd0);
    chk("clr_depth", 16'(Depth), 16'd0);
    chk("clr_top", Top, 16'd0);

    // Underflow straight after reset.
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 16'h00FF);
    tick(1'b1, 1'b1, 1'b0, 16'd0);
    chk("unf_status", 16'(Status), 16'd5);
    chk("unf_depth", 16'(Depth), 16'd1);
    chk("unf_top", Top, 16'h00FF);
    chk("unf_flags", 16'(Flags), 16'd0);

    // Wrap-around add: carry and zero set.
    tick(1'b0, 1'b0, 1'b1, 16'd0);
    tick(1'b1, 1'b0, 1'b0, 16'hFFFF);
    tick(1'b1, 1'b0, 1'b0, 16'h0001);
    tick(1'b1, 1'b1, 1'b0, 16'd0);
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    chk("wrap_top", Top, 16'h0000);
    chk("wrap_flags", 16'(Flags), 16'h0003);

    // Push pulse during EXEC is lost.
    tick(1'b0, 1'b0, 1'b1, 16'd0);
    tick(1'b1, 1'b0, 1'b0, 16'd1);
    tick(1'b1, 1'b0, 1'b0, 16'd2);
    tick(1'b1, 1'b1, 1'b0, 16'd0);
    tick(1'b1, 1'b0, 1'b0, 16'd8);
    chk("drop_depth", 16'(Depth), 16'd1);
    chk("drop_top", Top, 16'd3);
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    chk("drop_top2", Top, 16'd3);

    // Reset asserted in the middle of EXEC.
    tick(1'b1, 1'b0, 1'b0, 16'd6);
    tick(1'b1, 1'b1, 1'b0, 16'd3);
    chk("pre_rst_busy", 16'(Busy), 16'd1);
    do_reset();
    chk("exec_rst_busy", 16'(Busy), 16'd0);
    chk("exec_rst_depth", 16'(Depth), 16'd0);

    // Clear wins over a coincident push.
    tick(1'b1, 1'b0, 1'b0, 16'd11);
    tick(1'b1, 1'b0, 1'b1, 16'd7);
    chk("clrpush_depth", 16'(Depth), 16'd0);
    chk("clrpush_top", Top, 16'd0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      r_ep   = ($urandom % 3) == 0;
      r_isop = ($urandom % 2) == 0;
      r_clr  = ($urandom % 25) == 0;
      r_din  = 16'($urandom);
      if (($urandom % 150) == 0) do_reset();
      else tick(r_ep, r_isop, r_clr, r_din);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
